// File: rtl/cpu_pkg.sv
// Shared datapath types for the register-file write path.
// Default register count and bundle types live here.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int N_REGS_DEF = 4;
  localparam int AW_DEF     = $clog2(N_REGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter; owns the priority pointer.
// Reusable for any shared port (register file, memory bus).
module rr_arbiter #(
  parameter int  N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic          gnt_vld,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;

  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld    = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0
                                      : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin share of the register-file write port with a 1-cycle issue stage.
// Define REG_ZERO_PROTECT_EN to make register 0 a read-only zero.
module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int  N_REQ  = 3,
  parameter int  N_REGS = N_REGS_DEF,
  localparam int AW     = $clog2(N_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*8-1:0]  req_data,
  output logic [N_REQ-1:0]    req_grant,
  output logic [N_REGS-1:0]   reg_write,
  output logic [7:0]          reg_data,
  output logic [7:0]          contention_cnt
);

  localparam int PW = $clog2(N_REQ);

`ifdef REG_ZERO_PROTECT_EN
  localparam bit ZERO_PROT = 1'b1;
`else
  localparam bit ZERO_PROT = 1'b0;
`endif

  logic [AW-1:0]     addr_arr [N_REQ];
  reg_data_t         data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*AW +: AW];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  logic          arb_en;
  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;

  assign arb_en = !stall && !reset;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (arb_en),
    .grant   (req_grant),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  logic [AW-1:0]     sel_addr;
  reg_data_t         sel_data;
  logic              sel_zero;
  logic              multi;
  logic [N_REGS-1:0] reg_write_q, reg_write_d;
  reg_data_t         reg_data_q, reg_data_d;
  logic [7:0]        cnt_q, cnt_d;

  always_comb begin
    sel_addr    = addr_arr[gnt_idx];
    sel_data    = data_arr[gnt_idx];
    sel_zero    = ZERO_PROT && (sel_addr == '0);
    reg_write_d = '0;
    reg_data_d  = reg_data_q;
    // Out-of-range or protected targets are consumed without a write
    if (gnt_vld && !sel_zero) begin
      reg_data_d = sel_data;
      if (int'(sel_addr) < N_REGS) begin
        reg_write_d[sel_addr] = 1'b1;
      end
    end
    multi = $countones(req_valid) > 1;
    cnt_d = cnt_q;
    if (multi && arb_en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= '0;
      reg_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      reg_data_q  <= reg_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign reg_data       = reg_data_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table, corner sequences, random vs model.
// Expectations follow REG_ZERO_PROTECT_EN when it is defined.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  req_valid;
  logic [5:0]  req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_grant;
  logic [3:0]  reg_write;
  logic [7:0]  reg_data;
  logic [7:0]  contention_cnt;

  int total = 0;
  int bad   = 0;

`ifdef REG_ZERO_PROTECT_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  reg_write_arbiter #(.N_REQ(3), .N_REGS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_grant      (req_grant),
    .reg_write      (reg_write),
    .reg_data       (reg_data),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] v,
                       input logic [5:0] a, input logic [23:0] d);
    stall     = st;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  v;
    logic [5:0]  a;
    logic [23:0] d;
    logic [2:0]  g;
    logic [3:0]  w;
    logic [7:0]  rd;
    logic [7:0]  c;
  } vec_t;

  localparam logic [5:0]  A123 = 6'b11_10_01;
  localparam logic [23:0] D123 = 24'h33_22_11;
  localparam logic [5:0]  AS   = 6'b00_00_01;
  localparam logic [23:0] DS   = 24'h00_00_77;
  localparam logic [5:0]  AB   = 6'b00_10_10;
  localparam logic [23:0] DB   = 24'h00_B2_A1;

  vec_t tbl [17];

  // reference model state
  int         m_ptr;
  logic [3:0] m_wr;
  logic [7:0] m_data;
  int         m_cnt;

  function automatic int winner(input logic [2:0] v,
                                input logic st, input int ptr);
    if (st) return -1;
    for (int k = 0; k < 3; k++)
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic model_step(input logic st, input logic [2:0] v,
                            input logic [5:0] a, input logic [23:0] d);
    int w;
    int ad;
    w = winner(v, st, m_ptr);
    if (w >= 0) begin
      ad    = int'((a >> (2 * w)) & 6'h3);
      m_ptr = (w + 1) % 3;
      if (ZP && ad == 0) begin
        m_wr = 4'b0000;
      end else begin
        m_wr   = 4'b0001 << ad;
        m_data = 8'((d >> (8 * w)) & 24'hFF);
      end
    end else begin
      m_wr = 4'b0000;
    end
    if (!st && (int'(v[0]) + int'(v[1]) + int'(v[2])) > 1)
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  initial begin
    tbl[0]  = '{0, 3'b111, A123, D123, 3'b001, 4'b0000, 8'h00, 8'd0};
    tbl[1]  = '{0, 3'b010, 6'b001000, 24'h005A00,
                3'b010, 4'b0010, 8'h11, 8'd1};
    tbl[2]  = '{0, 3'b000, 6'd0, 24'd0, 3'b000, 4'b0100, 8'h5A, 8'd1};
    tbl[3]  = '{0, 3'b111, A123, D123, 3'b100, 4'b0000, 8'h5A, 8'd1};
    tbl[4]  = '{0, 3'b111, A123, D123, 3'b001, 4'b1000, 8'h33, 8'd2};
    tbl[5]  = '{0, 3'b111, A123, D123, 3'b010, 4'b0010, 8'h11, 8'd3};
    tbl[6]  = '{0, 3'b111, A123, D123, 3'b100, 4'b0100, 8'h22, 8'd4};
    tbl[7]  = '{0, 3'b111, A123, D123, 3'b001, 4'b1000, 8'h33, 8'd5};
    tbl[8]  = '{0, 3'b111, A123, D123, 3'b010, 4'b0010, 8'h11, 8'd6};
    tbl[9]  = '{1, 3'b001, AS, DS, 3'b000, 4'b0100, 8'h22, 8'd7};
    tbl[10] = '{1, 3'b001, AS, DS, 3'b000, 4'b0000, 8'h22, 8'd7};
    tbl[11] = '{1, 3'b101, AS, DS, 3'b000, 4'b0000, 8'h22, 8'd7};
    tbl[12] = '{0, 3'b001, AS, DS, 3'b001, 4'b0000, 8'h22, 8'd7};
    tbl[13] = '{0, 3'b000, 6'd0, 24'd0, 3'b000, 4'b0010, 8'h77, 8'd7};
    tbl[14] = '{0, 3'b011, AB, DB, 3'b010, 4'b0000, 8'h77, 8'd7};
    tbl[15] = '{0, 3'b001, AB, DB, 3'b001, 4'b0100, 8'hB2, 8'd8};
    tbl[16] = '{0, 3'b000, 6'd0, 24'd0, 3'b000, 4'b0100, 8'hA1, 8'd8};

    // reset held two cycles with every requester asking
    reset = 1'b1;
    drive(0, 3'b111, A123, D123);
    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", 32'(req_grant), 32'h0);
    chk("rst_wr",    32'(reg_write), 32'h0);
    chk("rst_data",  32'(reg_data),  32'h0);
    chk("rst_cnt",   32'(contention_cnt), 32'h0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(req_grant), 32'(tbl[i].g));
      chk($sformatf("v%0d_wr", i),    32'(reg_write), 32'(tbl[i].w));
      chk($sformatf("v%0d_data", i),  32'(reg_data),  32'(tbl[i].rd));
      chk($sformatf("v%0d_cnt", i),   32'(contention_cnt), 32'(tbl[i].c));
      tick();
    end

    // reset while a write sits in the issue stage
    drive(0, 3'b010, 6'b001100, 24'h00C300);
    @(negedge clk);
    chk("pre_grant", 32'(req_grant), 32'h2);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_grant", 32'(req_grant), 32'h0);
    chk("midrst_pend",  32'(reg_write), 32'h8);
    tick();
    reset = 1'b0;
    drive(0, 3'b000, 6'd0, 24'd0);
    @(negedge clk);
    chk("drop_wr",   32'(reg_write), 32'h0);
    chk("drop_data", 32'(reg_data),  32'h0);
    chk("drop_cnt",  32'(contention_cnt), 32'h0);
    tick();
    drive(0, 3'b010, 6'b001100, 24'h00C300);
    @(negedge clk);
    chk("repres_grant", 32'(req_grant), 32'h2);
    tick();
    drive(0, 3'b000, 6'd0, 24'd0);
    @(negedge clk);
    chk("repres_wr",   32'(reg_write), 32'h8);
    chk("repres_data", 32'(reg_data),  32'hC3);
    tick();

    // saturation of the contention counter
    drive(0, 3'b111, A123, D123);
    for (int i = 0; i < 254; i++) tick();
    @(negedge clk);
    chk("cnt_254", 32'(contention_cnt), 32'd254);
    tick();
    @(negedge clk);
    chk("cnt_255", 32'(contention_cnt), 32'hFF);
    for (int i = 0; i < 45; i++) tick();
    @(negedge clk);
    chk("cnt_sat", 32'(contention_cnt), 32'hFF);

    // write to register 0 with data FF
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 3'b001, 6'b000000, 24'h0000FF);
    @(negedge clk);
    chk("z_grant", 32'(req_grant), 32'h1);
    tick();
    drive(0, 3'b000, 6'd0, 24'd0);
    @(negedge clk);
    chk("z_wr",   32'(reg_write), ZP ? 32'h0 : 32'h1);
    chk("z_data", 32'(reg_data),  ZP ? 32'h0 : 32'hFF);

    // randomized run against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ptr  = 0;
    m_wr   = 4'b0000;
    m_data = 8'h00;
    m_cnt  = 0;
    for (int i = 0; i < 600; i++) begin
      logic        st;
      logic [2:0]  v;
      logic [5:0]  a;
      logic [23:0] d;
      int          w;
      st = ($urandom_range(0, 3) == 0);
      v  = 3'($urandom);
      a  = 6'($urandom);
      d  = 24'($urandom);
      drive(st, v, a, d);
      @(negedge clk);
      w = winner(v, st, m_ptr);
      chk("r_grant", 32'(req_grant),
          (w >= 0) ? (32'h1 << w) : 32'h0);
      chk("r_wr",   32'(reg_write), 32'(m_wr));
      chk("r_data", 32'(reg_data),  32'(m_data));
      chk("r_cnt",  32'(contention_cnt), 32'(m_cnt));
      tick();
      model_step(st, v, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port among N_REQ datapath requesters (ALU result, memory load, immediate load, ...) using round-robin arbitration.
- Drives one-hot write enables and a shared 8-bit data bus into the bank of 8-bit registers (synchronous reset, write-enable, load on posedge clk).
- Has one registered issue stage and a saturating contention counter for performance debug.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- N_REGS, 4, number of 8-bit registers on the write port (power of 2, 2..16).
- AW, $clog2(N_REGS), register address width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  control-unit hold; no new grants while high.
- req_valid  input  N_REQ  per-requester write request.
- req_addr  input  N_REQ*AW  packed target register index, requester i at [i*AW +: AW].
- req_data  input  N_REQ*8  packed write data, requester i at [i*8 +: 8].
- req_grant  output  N_REQ  one-hot; requester i accepted this cycle.
- reg_write  output  N_REGS  one-hot write enable to register bank.
- reg_data  output  8  shared write data to register bank.
- contention_cnt  output  8  saturating count of cycles with more than one request pending.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On reset: req_grant=0, reg_write=0, reg_data=8'h00, contention_cnt=8'h00, and the round-robin pointer is set to 0 (requester 0 has highest priority first).
- Handshake: a requester asserts req_valid with stable addr/data until it sees req_grant for one cycle. Grant is combinational from current req_valid, stall and pointer, so the grant occurs in the same cycle as the request when uncontended.
- Arbitration: the winner is the first valid requester searching from pointer upward, wrapping from N_REQ-1 to 0. There is at most one grant per cycle. When a grant is made, pointer <= winner+1, wrapping to 0 after N_REQ-1. With no grant, the pointer holds.
- Stall: while stall=1, req_grant=0 and the pointer holds. A write already in the issue stage still completes.
- Issue stage (latency 1):
  - The cycle after a grant, reg_write = one-hot(addr of winner) and reg_data = data of winner, for exactly one cycle.
  - In cycles with no grant, reg_write=0 and reg_data holds its last value.
  - The register therefore captures the data 2 posedges after req_valid rises in the uncontended case.
- Back-to-back: sustained throughput is one write per cycle. If two requesters target the same register in consecutive grants, the later grant's data is what remains in the register.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,... Every requester is granted within N_REQ cycles of raising valid, provided stall stays low.
- Contention counter:
  - Increments by 1 in each cycle where popcount(req_valid)>1 and stall=0.
  - Saturates at 8'hFF, with no wrap.
  - Clears only on reset.
- Reset mid-operation: a pending issue-stage write is dropped, so no reg_write in the cycle after reset. Requesters must re-present their requests after reset deasserts.
- Out-of-range: if N_REGS is not a power of 2, an addr >= N_REGS is granted and consumed, but reg_write stays 0.

Optional Feature:
- Macro: REG_ZERO_PROTECT_EN.
- When defined: register index 0 is treated as constant zero. Requests to addr 0 are still granted and advance the pointer, but produce reg_write=0 in the issue stage. They also do not update reg_data.
- When undefined: addr 0 is an ordinary writable register.

Decomposition:
- Shared package cpu_pkg holds:
  - constants DATA_W=8 and the default N_REGS;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef wr_req_t (struct: valid, addr, data).
- One natural sub-module, rr_arbiter: a generic N-way round-robin arbiter with req vector, enable and grant one-hot, owning the pointer. It is reusable for memory-bus sharing.
- reg_write_arbiter adds the data/address muxing, the issue stage and the counter.

Test Plan:
- Reset: hold reset 2 cycles with all req_valid=1 -> req_grant=0, reg_write=0, reg_data=00, contention_cnt=00. The first grant after release goes to requester 0.
- Single request: req 1 valid, addr=2, data=8'h5A -> req_grant=3'b010 in the same cycle. Next cycle reg_write=4'b0100, reg_data=5A.
- Round-robin: all 3 requesters held valid for 6 cycles -> grants 0,1,2,0,1,2; contention_cnt=6.
- Stall: req 0 valid with stall=1 for 3 cycles -> no grant and the pointer is unchanged. Grant to requester 0 arrives in the cycle stall drops.
- Saturation: 300 contended cycles -> contention_cnt=FF and it stays FF.
- REG_ZERO_PROTECT_EN defined: req 0 writes addr 0 with data 8'hFF -> grant asserted, next-cycle reg_write=0, reg_data unchanged.
